sub_tc_16_16_pipe: RTL and testbench



---
 rtl/sub_tc_16_16_pipe_pkg.sv | 45 ++++
 rtl/sub_tc_16_16_pipe_cla8.sv | 47 ++++
 rtl/sub_tc_16_16_pipe.sv | 122 ++++++++++++
 tb/tb_sub_tc_16_16_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_tc_16_16_pipe_pkg.sv
//==============================================================================
// Module      : sub_tc_16_16_pipe_pkg
// Description : Shared widths, stage-1 payload type and 4-bit lookahead helpers
//               for the pipelined two's-complement subtractor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sub_tc_16_16_pipe_pkg;

    localparam int TC_WIDTH = 16;
    localparam int TC_HALF  = TC_WIDTH / 2;
    localparam int TC_RES_W = TC_WIDTH + 1;

    // Everything the high half needs once the low half has been resolved.
    typedef struct packed {
        logic [TC_HALF-1:0] lo_sum;
        logic               c8;
        logic [TC_HALF-1:0] a_hi;
        logic [TC_HALF-1:0] nb_hi;
    } s1_t;

    // Carries into bits 1..3 of a 4-bit group, returned as {c3, c2, c1}.
    function automatic logic [2:0] cla4_carries(input logic [3:0] p,
                                                input logic [3:0] g,
                                                input logic       ci);
        logic c1, c2, c3;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return {c3, c2, c1};
    endfunction

    // Group generate/propagate of a 4-bit group, returned as {G, P}.
    function automatic logic [1:0] cla4_gp(input logic [3:0] p,
                                           input logic [3:0] g);
        logic gg, pp;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp = &p;
        return {gg, pp};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sub_tc_16_16_pipe_cla8.sv
//==============================================================================
// Module      : cla8_add
// Description : 8-bit carry-lookahead adder, two 4-bit p/g groups joined by a
//               group-level lookahead; also exposes the carry into bit 7.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cla8_add
    import sub_tc_16_16_pipe_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       c7
);

    logic [7:0] w_p;
    logic [7:0] w_g;
    logic [1:0] w_gp_lo;
    logic [1:0] w_gp_hi;
    logic       w_c4;
    logic [2:0] w_c_lo;
    logic [2:0] w_c_hi;
    logic [7:0] w_c;

    assign w_p     = x ^ y;
    assign w_g     = x & y;
    assign w_gp_lo = cla4_gp(w_p[3:0], w_g[3:0]);
    assign w_gp_hi = cla4_gp(w_p[7:4], w_g[7:4]);

    // Group-level lookahead: both group carries come straight from cin.
    assign w_c4 = w_gp_lo[1] | (w_gp_lo[0] & cin);
    assign cout = w_gp_hi[1] | (w_gp_hi[0] & w_gp_lo[1]) | (w_gp_hi[0] & w_gp_lo[0] & cin);

    assign w_c_lo = cla4_carries(w_p[3:0], w_g[3:0], cin);
    assign w_c_hi = cla4_carries(w_p[7:4], w_g[7:4], w_c4);

    assign w_c = {w_c_hi, w_c4, w_c_lo, cin};
    assign s   = w_p ^ w_c;
    assign c7  = w_c_hi[2];

endmodule

`default_nettype wire

// File: rtl/sub_tc_16_16_pipe.sv
//==============================================================================
// Module      : sub_tc_16_16_pipe
// Description : Two-stage valid/ready pipelined 16-bit two's-complement
//               subtractor producing the exact 17-bit difference a - b.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sub_tc_16_16_pipe
    import sub_tc_16_16_pipe_pkg::*;
#(
    parameter int WIDTH = TC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;

    logic             s1_v_q,      s1_v_d;
    s1_t              s1_q,        s1_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   diff_q,      diff_d;
    logic             ovf_q,       ovf_d;

    logic [WIDTH-1:0] w_nb;
    logic [HALF-1:0]  w_lo_sum;
    logic             w_c8;
    logic             w_lo_c7_unused;
    logic [HALF-1:0]  w_hi_sum;
    logic             w_c16;
    logic             w_c15;
    logic             w_msb;
    logic             w_s2_adv;
    logic             w_accept;

    assign w_nb = ~b;

    // Low half: a + ~b + 1 starts the subtraction.
    cla8_add u_cla_lo (
        .x    (a[HALF-1:0]),
        .y    (w_nb[HALF-1:0]),
        .cin  (1'b1),
        .s    (w_lo_sum),
        .cout (w_c8),
        .c7   (w_lo_c7_unused)
    );

    cla8_add u_cla_hi (
        .x    (s1_q.a_hi),
        .y    (s1_q.nb_hi),
        .cin  (s1_q.c8),
        .s    (w_hi_sum),
        .cout (w_c16),
        .c7   (w_c15)
    );

    // Sign extension of both operands collapses bit 16 to a single XOR;
    // diff[16]^diff[15] then reduces to c16^c15.
    assign w_msb = s1_q.a_hi[HALF-1] ^ s1_q.nb_hi[HALF-1] ^ w_c16;

    assign w_s2_adv = s1_v_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_v_q | w_s2_adv;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        s1_d        = s1_q;
        s1_v_d      = s1_v_q;
        diff_d      = diff_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        if (w_accept) begin
            s1_d.lo_sum = w_lo_sum;
            s1_d.c8     = w_c8;
            s1_d.a_hi   = a[WIDTH-1:HALF];
            s1_d.nb_hi  = w_nb[WIDTH-1:HALF];
            s1_v_d      = 1'b1;
        end else if (w_s2_adv) begin
            s1_v_d = 1'b0;
        end

        if (w_s2_adv) begin
            diff_d      = {w_msb, w_hi_sum, s1_q.lo_sum};
            ovf_d       = w_c16 ^ w_c15;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s1_v_q      <= 1'b0;
            diff_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_v_q      <= s1_v_d;
            diff_q      <= diff_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sub_tc_16_16_pipe.sv
//==============================================================================
// Module      : tb_sub_tc_16_16_pipe
// Description : Directed and random self-checking bench for sub_tc_16_16_pipe.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sub_tc_16_16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] diff;
    logic        ovf;

    typedef struct {
        logic [16:0] d;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;

    sub_tc_16_16_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model_diff(input logic [15:0] x, input logic [15:0] y);
        return {x[15], x} - {y[15], y};
    endfunction

    // One cycle: drive, settle, score handshakes, then advance to edge+1.
    task automatic drive_cycle(input logic v, input logic [15:0] av, input logic [15:0] bv,
                               input logic ordy, input logic [16:0] ed, input logic eo,
                               output logic acc);
        exp_t e;
        in_valid  = v;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("stream_diff", 32'(diff), 32'(e.d));
                check("stream_ovf", 32'(ovf), 32'(e.o));
                n_out++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back('{d: ed, o: eo});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int   n;
        logic acc;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 17'h0, 1'b0, acc);
            n++;
        end
        if (q.size() != 0) check({tag, "_timeout"}, 32'(q.size()), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input string tag, input logic [15:0] av, input logic [15:0] bv,
                             input logic [16:0] ed, input logic eo);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_v1"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_v2"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk);
        #1;
        check({tag, "_gone"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] da [5] = '{16'h8000, 16'h0001, 16'h0100, 16'h0000, 16'hFFFF};
    logic [15:0] db [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h7FFF};
    logic [16:0] dd [5] = '{17'h17FFF, 17'h00000, 17'h000FF, 17'h08000, 17'h18000};
    logic        dov[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    logic [15:0] pa [4] = '{16'h0003, 16'h1234, 16'h0000, 16'h7FFF};
    logic [15:0] pb [4] = '{16'h0001, 16'h0234, 16'h0001, 16'h8000};
    logic [16:0] pd [4] = '{17'h00002, 17'h01000, 17'h1FFFF, 17'h0FFFF};
    logic        pov[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic        acc;
        logic [15:0] ra, rb;
        logic [16:0] rd;
        int          idx;
        int          n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        lat_check("max_minus_neg1", 16'h7FFF, 16'hFFFF, 17'h08000, 1'b1);

        // Back-to-back directed vectors.
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, da[i], db[i], 1'b1, dd[i], dov[i], acc);
            check("dir_accept", 32'(acc), 32'd1);
        end
        drain("dir");

        // Backpressure: consumer stalled for 5 cycles.
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, pa[idx], pb[idx], 1'b0, pd[idx], pov[idx], acc);
            if (acc) idx++;
            if (c >= 1) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_diff", 32'(diff), 32'(pd[0]));
            end
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        n_out = 0;
        n     = 0;
        while ((idx < 4 || q.size() > 0) && n < 30) begin
            if (idx < 4) begin
                drive_cycle(1'b1, pa[idx], pb[idx], 1'b1, pd[idx], pov[idx], acc);
                if (acc) idx++;
            end else begin
                drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, 17'h0, 1'b0, acc);
            end
            n++;
        end
        check("bp_out_count", 32'(n_out), 32'd4);
        in_valid = 1'b0;

        // Reset with both stages full.
        drive_cycle(1'b1, 16'h1111, 16'h0001, 1'b0, 17'h01110, 1'b0, acc);
        drive_cycle(1'b1, 16'h2222, 16'h0002, 1'b0, 17'h02220, 1'b0, acc);
        check("mid_full_in_ready", 32'(in_ready), 32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        lat_check("post_rst", 16'h0005, 16'h0007, 17'h1FFFE, 1'b0);

        // Random traffic against the arithmetic reference.
        for (int i = 0; i < 400; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rd = model_diff(ra, rb);
            drive_cycle(($urandom % 4) != 0, ra, rb, ($urandom % 3) != 0, rd, rd[16] ^ rd[15], acc);
        end
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
